// File: rtl/cart_axi_initiator_if.sv
// AXI4-Lite channel bundle between the cartridge initiator and the DRAM side.
// master: the initiator drives valids/addresses/data and the response readies.
interface cart_axi_initiator_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/cart_axi_initiator.sv
// Translates single-byte cartridge accesses into AXI4-Lite word transactions
// against a DRAM-resident cartridge image; one transaction outstanding at most.
module cart_axi_initiator #(
    parameter int unsigned ADDR_WIDTH = 23
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           base_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  resp_valid,
    output logic [7:0]            resp_rdata,
    output logic                  resp_error,
    output logic                  err_sticky,
    input  logic                  err_clear,
    cart_axi_initiator_if.master  axi
);

    typedef enum logic [2:0] {
        IDLE,
        READ_ADDR,
        READ_DATA,
        WRITE,
        WRITE_RESP,
        DONE
    } state_t;

    state_t      r_state;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic [31:0] r_araddr;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_lane;
    logic        r_resp_valid;
    logic [7:0]  r_resp_rdata;
    logic        r_resp_error;
    logic        r_err_sticky;

    logic [31:0] w_addr;
    logic        w_aw_done;
    logic        w_w_done;

    assign w_addr    = base_addr + 32'(req_addr);
    // AW and W finish independently; either may already be done or finish now.
    assign w_aw_done = !r_awvalid || axi.awready;
    assign w_w_done  = !r_wvalid  || axi.wready;

    assign req_ready   = (r_state == IDLE) && !reset;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_error  = r_resp_error;
    assign err_sticky  = r_err_sticky;

    assign axi.arvalid = r_arvalid;
    assign axi.araddr  = r_araddr;
    assign axi.rready  = r_rready;
    assign axi.awvalid = r_awvalid;
    assign axi.awaddr  = r_awaddr;
    assign axi.wvalid  = r_wvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.bready  = r_bready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_lane       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;

            // A new error outranks a clear arriving on the same edge.
            if (r_resp_valid && r_resp_error) begin
                r_err_sticky <= 1'b1;
            end else if (err_clear) begin
                r_err_sticky <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_lane <= w_addr[1:0];
                        if (req_write) begin
                            r_awaddr  <= {w_addr[31:2], 2'b00};
                            r_wdata   <= {4{req_wdata}};
                            r_wstrb   <= 4'b0001 << w_addr[1:0];
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WRITE;
                        end else begin
                            r_araddr  <= {w_addr[31:2], 2'b00};
                            r_arvalid <= 1'b1;
                            r_state   <= READ_ADDR;
                        end
                    end
                end

                READ_ADDR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= READ_DATA;
                    end
                end

                READ_DATA: begin
                    if (axi.rvalid) begin
                        r_rready     <= 1'b0;
                        r_resp_rdata <= axi.rdata[{r_lane, 3'b000} +: 8];
                        r_resp_error <= |axi.rresp;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end

                WRITE: begin
                    if (axi.awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (axi.wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WRITE_RESP;
                    end
                end

                WRITE_RESP: begin
                    if (axi.bvalid) begin
                        r_bready     <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_error <= |axi.bresp;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_axi_initiator.sv
// Directed and randomized bench for cart_axi_initiator; the bench itself plays the
// AXI target, and expectations come from address/lane arithmetic on the request.
module tb_cart_axi_initiator;

    localparam int unsigned AW = 23;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   base_addr;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_wdata;
    logic          resp_valid;
    logic [7:0]    resp_rdata;
    logic          resp_error;
    logic          err_sticky;
    logic          err_clear;

    cart_axi_initiator_if axi();

    cart_axi_initiator #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .base_addr  (base_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .err_sticky (err_sticky),
        .err_clear  (err_clear),
        .axi        (axi)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    logic m_sticky = 1'b0;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the DONE cycle, then the cycle after it (pulse gone, data held, sticky).
    task automatic finish_resp(input logic [7:0] exp_data, input logic exp_err, input logic clr);
        chk("resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("resp_rdata", {24'b0, resp_rdata}, {24'b0, exp_data});
        chk("resp_error", {31'b0, resp_error}, {31'b0, exp_err});
        err_clear = clr;
        tick();
        err_clear = 1'b0;
        if (exp_err) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        chk("resp_pulse_len", {31'b0, resp_valid}, 32'd0);
        chk("req_ready_after_done", {31'b0, req_ready}, 32'd1);
        chk("resp_rdata_hold", {24'b0, resp_rdata}, {24'b0, exp_data});
        chk("resp_error_hold", {31'b0, resp_error}, {31'b0, exp_err});
        chk("err_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
    endtask

    task automatic read_txn(input logic [31:0] base, input logic [AW-1:0] addr,
                            input logic [31:0] data, input logic [1:0] resp,
                            input int arw, input int rw, input logic clr);
        logic [31:0] a;
        logic [7:0]  exp_byte;
        int          n;
        a        = base + 32'(addr);
        exp_byte = 8'(data >> (8 * a[1:0]));
        base_addr = base;
        req_addr  = addr;
        req_write = 1'b0;
        req_wdata = 8'($urandom);
        req_valid = 1'b1;
        chk("rd_req_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (axi.arvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("rd_arvalid", {31'b0, axi.arvalid}, 32'd1);
        chk("rd_araddr", axi.araddr, {a[31:2], 2'b00});
        chk("rd_req_ready_busy", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < arw; i++) begin
            tick();
            chk("rd_arvalid_hold", {31'b0, axi.arvalid}, 32'd1);
            chk("rd_araddr_hold", axi.araddr, {a[31:2], 2'b00});
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("rd_arvalid_drop", {31'b0, axi.arvalid}, 32'd0);
        for (int i = 0; i < rw; i++) begin
            chk("rd_rready_wait", {31'b0, axi.rready}, 32'd1);
            chk("rd_no_early_resp", {31'b0, resp_valid}, 32'd0);
            tick();
        end
        chk("rd_rready", {31'b0, axi.rready}, 32'd1);
        chk("rd_no_early_resp", {31'b0, resp_valid}, 32'd0);
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rresp  = resp;
        tick();
        axi.rvalid = 1'b0;
        axi.rdata  = $urandom;
        axi.rresp  = 2'($urandom);
        chk("rd_rready_drop", {31'b0, axi.rready}, 32'd0);
        finish_resp(exp_byte, resp != 2'b00, clr);
    endtask

    task automatic write_txn(input logic [31:0] base, input logic [AW-1:0] addr,
                             input logic [7:0] wbyte, input logic [1:0] resp,
                             input int aww, input int ww, input int bw, input logic clr);
        logic [31:0] a;
        logic [3:0]  exp_strb;
        logic        aw_done;
        logic        w_done;
        int          aw_left;
        int          w_left;
        int          n;
        a        = base + 32'(addr);
        exp_strb = 4'(1 << a[1:0]);
        aw_done  = 1'b0;
        w_done   = 1'b0;
        aw_left  = aww;
        w_left   = ww;
        base_addr = base;
        req_addr  = addr;
        req_write = 1'b1;
        req_wdata = wbyte;
        req_valid = 1'b1;
        chk("wr_req_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("wr_awaddr", axi.awaddr, {a[31:2], 2'b00});
        chk("wr_wdata", axi.wdata, {4{wbyte}});
        chk("wr_wstrb", {28'b0, axi.wstrb}, {28'b0, exp_strb});
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            axi.awready = (aw_left == 0);
            axi.wready  = (w_left == 0);
            chk("wr_awvalid", {31'b0, axi.awvalid}, {31'b0, !aw_done});
            chk("wr_wvalid", {31'b0, axi.wvalid}, {31'b0, !w_done});
            chk("wr_bready_early", {31'b0, axi.bready}, 32'd0);
            chk("wr_awaddr_hold", axi.awaddr, {a[31:2], 2'b00});
            tick();
            n++;
            if (aw_left == 0) aw_done = 1'b1; else aw_left--;
            if (w_left == 0) w_done = 1'b1; else w_left--;
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        chk("wr_awvalid_done", {31'b0, axi.awvalid}, 32'd0);
        chk("wr_wvalid_done", {31'b0, axi.wvalid}, 32'd0);
        for (int i = 0; i < bw; i++) begin
            chk("wr_bready_wait", {31'b0, axi.bready}, 32'd1);
            chk("wr_no_early_resp", {31'b0, resp_valid}, 32'd0);
            tick();
        end
        chk("wr_bready", {31'b0, axi.bready}, 32'd1);
        chk("wr_no_early_resp", {31'b0, resp_valid}, 32'd0);
        axi.bvalid = 1'b1;
        axi.bresp  = resp;
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'($urandom);
        chk("wr_bready_drop", {31'b0, axi.bready}, 32'd0);
        finish_resp(8'h00, resp != 2'b00, clr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        base_addr   = '0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        err_clear   = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = '0;
        repeat (3) tick();

        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
        chk("rst_awvalid", {31'b0, axi.awvalid}, 32'd0);
        chk("rst_wvalid", {31'b0, axi.wvalid}, 32'd0);
        chk("rst_rready", {31'b0, axi.rready}, 32'd0);
        chk("rst_bready", {31'b0, axi.bready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", {24'b0, resp_rdata}, 32'd0);
        chk("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        chk("rst_awaddr", axi.awaddr, 32'd0);
        chk("rst_wdata", axi.wdata, 32'd0);
        chk("rst_wstrb", {28'b0, axi.wstrb}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // Directed cases from the requirements list.
        read_txn(32'h1000_0000, 23'h5, 32'hDDCC_BBAA, 2'b00, 0, 0, 1'b0);
        write_txn(32'h1000_0000, 23'h3, 8'h5A, 2'b00, 4, 0, 0, 1'b0);
        read_txn(32'h1000_0000, 23'h2, 32'h1234_5678, 2'b10, 1, 2, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        m_sticky  = 1'b0;
        chk("err_clear", {31'b0, err_sticky}, 32'd0);
        read_txn(32'h1000_0000, 23'h7, 32'hCAFE_F00D, 2'b11, 0, 0, 1'b1);
        read_txn(32'hFFFF_FFFE, 23'h3, 32'h4433_2211, 2'b00, 0, 0, 1'b0);
        chk("wrap_sticky_kept", {31'b0, err_sticky}, 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        m_sticky  = 1'b0;
        write_txn(32'h0800_0001, 23'h7F_FFFF, 8'hC3, 2'b10, 1, 3, 2, 1'b0);

        // Responses offered while idle are not accepted.
        axi.rvalid = 1'b1;
        axi.bvalid = 1'b1;
        repeat (2) begin
            tick();
            chk("idle_rready", {31'b0, axi.rready}, 32'd0);
            chk("idle_bready", {31'b0, axi.bready}, 32'd0);
            chk("idle_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        axi.rvalid = 1'b0;
        axi.bvalid = 1'b0;

        // Reset while waiting in READ_DATA.
        base_addr = 32'h3000_0000;
        req_addr  = 23'h11;
        req_write = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid   = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("mid_rready", {31'b0, axi.rready}, 32'd1);
        reset      = 1'b1;
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hFFFF_FFFF;
        tick();
        m_sticky = 1'b0;
        chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_rready", {31'b0, axi.rready}, 32'd0);
        chk("mid_rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
        chk("mid_rst_awvalid", {31'b0, axi.awvalid}, 32'd0);
        chk("mid_rst_wvalid", {31'b0, axi.wvalid}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_resp_rdata", {24'b0, resp_rdata}, 32'd0);
        chk("mid_rst_resp_error", {31'b0, resp_error}, 32'd0);
        chk("mid_rst_sticky", {31'b0, err_sticky}, 32'd0);
        chk("mid_rst_araddr", axi.araddr, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_release_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) begin
            tick();
            chk("mid_after_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        axi.rvalid = 1'b0;
        read_txn(32'h3000_0000, 23'h12, 32'hA1B2_C3D4, 2'b00, 0, 0, 1'b0);

        // Back-to-back reads with req_valid held, zero-wait target.
        base_addr   = 32'h2000_0000;
        req_addr    = 23'h1;
        req_write   = 1'b0;
        req_valid   = 1'b1;
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h8765_4321;
        axi.rresp   = 2'b00;
        chk("b2b_ready0", {31'b0, req_ready}, 32'd1);
        tick();
        req_addr = 23'h6;
        for (int i = 0; i < 2; i++) begin
            chk("b2b_busy_ready", {31'b0, req_ready}, 32'd0);
            chk("b2b_busy_resp", {31'b0, resp_valid}, 32'd0);
            tick();
        end
        chk("b2b_done1", {31'b0, resp_valid}, 32'd1);
        chk("b2b_data1", {24'b0, resp_rdata}, 32'h43);
        chk("b2b_done_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("b2b_ready_after_done", {31'b0, req_ready}, 32'd1);
        chk("b2b_idle_arvalid", {31'b0, axi.arvalid}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("b2b_second_ar", {31'b0, axi.arvalid}, 32'd1);
        chk("b2b_second_addr", axi.araddr, 32'h2000_0004);
        chk("b2b_second_busy", {31'b0, req_ready}, 32'd0);
        tick();
        tick();
        chk("b2b_done2", {31'b0, resp_valid}, 32'd1);
        chk("b2b_data2", {24'b0, resp_rdata}, 32'h65);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        tick();

        // Randomized mix of reads and writes with random stalls and responses.
        for (int t = 0; t < 24; t++) begin
            logic [31:0]   rb;
            logic [AW-1:0] ra;
            logic [1:0]    rr;
            rb = $urandom;
            ra = AW'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1)
                write_txn(rb, ra, 8'($urandom), rr, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else
                read_txn(rb, ra, $urandom, rr, $urandom_range(0, 3),
                         $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
